param_scan_mux: RTL
===================

Name: param_scan_mux

Overview:
- Parametrised N-channel, DATA_W-bit multiplexer with a registered output stage and valid/ready handshakes on every input channel and on the output.
- Two modes: manual (channel chosen by `sel`) and round-robin scan over channels presenting valid data.
- Successor to the lab's combinational 16:1 mux. Feeds serialising and display blocks that need one word per cycle, tagged with its source channel.

Parameters:
- N_CH, 16, number of input channels (2..64).
- SEL_W, 4, select/channel-index width; must satisfy 2**SEL_W >= N_CH.
- DATA_W, 8, bits per channel word.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N_CH*DATA_W  packed channel words; channel 0 occupies the most significant DATA_W bits, channel N_CH-1 the least significant.
- in_valid  input  N_CH  per-channel valid; bit i belongs to channel i, with bit 0 at the MSB end, matching in_data ordering.
- in_ready  output  N_CH  per-channel ready (combinational, at most one bit high).
- mode  input  1  0 = manual select, 1 = round-robin scan.
- sel  input  SEL_W  manual-mode channel index.
- out_data  output  DATA_W  registered selected word.
- out_ch  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0.
  - Scan pointer ptr=N_CH-1, so the first scan search starts at channel 0.
  - in_ready=0 while rst is high.
  - Any word in the output register is dropped, even mid-handshake.
- load = !out_valid || out_ready. The output register accepts a new word only when load is 1.
- Candidate selection, combinational, evaluated every cycle:
  - Manual (mode=0): cand=sel; hit = (sel < N_CH) && in_valid[sel]. An out-of-range sel never hits.
  - Scan (mode=1): cand = first i with in_valid[i]=1, searching in the order ptr+1, ptr+2, … modulo N_CH, with ptr itself checked last. hit = |in_valid.
- Grant:
  - grant = load && hit && !rst.
  - in_ready[cand] = grant; all other in_ready bits are 0.
  - A transfer occurs on channel i when in_valid[i] && in_ready[i].
- On a clk edge with grant=1: out_data <= word of cand; out_ch <= cand; out_valid <= 1; ptr <= cand. ptr updates in both modes.
- On a clk edge with load=1 and grant=0: out_valid <= 0; out_data and out_ch hold their last value.
- On a clk edge with load=0 (stall): all registers hold; out_data, out_ch and out_valid are stable under backpressure.
- Latency: exactly 1 cycle from the transfer cycle to out_valid=1.
- Throughput: 1 word per cycle when out_ready is held at 1.
- Round-robin fairness: with all channels valid continuously, grants are 0,1,…,N_CH-1,0,… Every valid channel is served within N_CH grants.
- Mode or sel changes take effect combinationally in the same cycle. A word already in the output register is unaffected.
- Simultaneous out_ready=1 and new grant: the old word completes and the new word is loaded on the same edge, with no bubble.
- Input channels whose in_valid drops before a grant are simply skipped; no state is kept per channel.

Test Plan:
1. Manual sweep (N_CH=16, DATA_W=8, mode=0, out_ready=1): channel i carries word 8'hA0+i, all in_valid=1, sel=0..15 one per cycle → one cycle later each time out_data=8'hA0+sel, out_ch=sel, out_valid=1; in_ready is one-hot at bit sel.
2. Round-robin scan (mode=1): in_valid has only channels 3, 7 and 12 high, out_ready=1 → out_ch sequence 3,7,12,3,7,…; in_ready pulses on exactly those channels.
3. Backpressure: out_ready=0 for 5 cycles after the first word (ch 3, 8'hA3) → out_data=8'hA3, out_ch=3, out_valid=1 stable; in_ready=0 throughout. After out_ready=1, the next word (ch 7) appears in the following cycle with no lost or duplicated words.
4. Out-of-range and empty inputs: (a) mode=0, N_CH=12, sel=13 → in_ready=0 and out_valid falls to 0 one cycle later. (b) mode=1 with in_valid=0 → out_valid=0 and out_data holds its last value.
5. Reset mid-operation: assert rst for one cycle while out_valid=1 and out_ready=0 → the next cycle shows out_valid=0, out_data=0, out_ch=0; the first subsequent scan with all channels valid grants channel 0.
6. Mode switch: scan until ptr=5, then mode=0 with sel=2 and all valid → next out_ch=2. Switch back to mode=1 → the next grant is channel 3 (ptr was updated to 2 by the manual grant).

Source files
------------

// File: rtl/param_scan_mux.sv
// N-channel valid/ready multiplexer with a registered output stage.
// Supports manual channel select and a round-robin scan over valid channels.
module param_scan_mux #(
    parameter int N_CH   = 16,
    parameter int SEL_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    // Channel 0 sits at the MSB end of the packed buses; remap to channel order.
    logic [N_CH-1:0]   vld;
    logic [DATA_W-1:0] word [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign vld[g]  = in_valid[N_CH-1-g];
        assign word[g] = in_data[(N_CH-1-g)*DATA_W +: DATA_W];
    end

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  cand;
    logic [SEL_W-1:0]  cand_hi;
    logic [SEL_W-1:0]  cand_lo;
    logic              any_hi;
    logic              any_lo;
    logic              hit;
    logic              load;
    logic              grant;
    logic [DATA_W-1:0] cand_word;

    assign load  = !out_valid || out_ready;
    assign grant = load && hit && !rst;

    // Round-robin split into channels above ptr (searched first) and the
    // rest up to and including ptr, so no modulo arithmetic is needed.
    // NOTE: every variable written here gets a default first; a missing
    // default on any path would infer a latch.
    always_comb begin
        cand_hi = '0;
        cand_lo = '0;
        any_hi  = 1'b0;
        any_lo  = 1'b0;
        for (int i = N_CH-1; i >= 0; i--) begin
            if (vld[i] && (SEL_W'(i) > ptr)) begin
                cand_hi = SEL_W'(i);
                any_hi  = 1'b1;
            end
            if (vld[i] && (SEL_W'(i) <= ptr)) begin
                cand_lo = SEL_W'(i);
                any_lo  = 1'b1;
            end
        end
    end

    always_comb begin
        cand = '0;
        hit  = 1'b0;
        if (!mode) begin
            cand = sel;
            // Comparing against every real channel rejects out-of-range sel.
            for (int i = 0; i < N_CH; i++) begin
                if (sel == SEL_W'(i)) hit = vld[i];
            end
        end else begin
            cand = any_hi ? cand_hi : cand_lo;
            hit  = any_hi || any_lo;
        end
    end

    always_comb begin
        cand_word = '0;
        in_ready  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cand == SEL_W'(i)) begin
                cand_word          = word[i];
                in_ready[N_CH-1-i] = grant;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SEL_W'(N_CH-1);
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= cand_word;
            out_ch    <= cand;
            ptr       <= cand;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule
